// File: rtl/layer_pingpong_scheduler.sv
// Ping-pong feature-bank scheduler between a producing layer and a consuming layer.
// Each side runs a RST/WAIT/RUN sequencer. Bank ownership follows the registered bank pointers.
module layer_pingpong_scheduler #(
  parameter int ADDR_WIDTH      = 9,
  parameter int DATA_WIDTH      = 16,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       former_enable,
  output logic                       former_reset,
  input  logic                       former_done,
  output logic                       next_enable,
  output logic                       next_reset,
  input  logic                       next_done,
  input  logic [ADDR_WIDTH-1:0]      former_addr_a,
  input  logic [ADDR_WIDTH-1:0]      former_addr_b,
  input  logic                       former_rden_a,
  input  logic                       former_rden_b,
  input  logic                       former_wren_a,
  input  logic                       former_wren_b,
  input  logic [ADDR_WIDTH-1:0]      next_addr_a,
  input  logic [ADDR_WIDTH-1:0]      next_addr_b,
  input  logic                       next_rden_a,
  input  logic                       next_rden_b,
  output logic [ADDR_WIDTH-1:0]      bank0_addr_a,
  output logic [ADDR_WIDTH-1:0]      bank0_addr_b,
  output logic [ADDR_WIDTH-1:0]      bank1_addr_a,
  output logic [ADDR_WIDTH-1:0]      bank1_addr_b,
  output logic                       bank0_rden_a,
  output logic                       bank0_rden_b,
  output logic                       bank0_wren_a,
  output logic                       bank0_wren_b,
  output logic                       bank1_rden_a,
  output logic                       bank1_rden_b,
  output logic                       bank1_wren_a,
  output logic                       bank1_wren_b,
  input  logic [DATA_WIDTH-1:0]      bank0_q_a,
  input  logic [DATA_WIDTH-1:0]      bank0_q_b,
  input  logic [DATA_WIDTH-1:0]      bank1_q_a,
  input  logic [DATA_WIDTH-1:0]      bank1_q_b,
  output logic [DATA_WIDTH-1:0]      next_q_a,
  output logic [DATA_WIDTH-1:0]      next_q_b,
  output logic                       wr_bank,
  output logic                       rd_bank,
  output logic [1:0]                 bank_full,
  output logic [FRAME_CNT_WIDTH-1:0] frames_done
);

  typedef enum logic [1:0] {ST_RST, ST_WAIT, ST_RUN} state_t;

  localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_ONE = {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t     former_state, former_state_nx;
  state_t     next_state, next_state_nx;
  logic       former_done_q, next_done_q;
  logic       former_finish, next_finish;
  logic [1:0] bank_full_nx;
  logic [1:0] former_sel, next_sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      former_state  <= ST_RST;
      next_state    <= ST_RST;
      former_done_q <= 1'b0;
      next_done_q   <= 1'b0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      bank_full     <= 2'b00;
      frames_done   <= '0;
    end else begin
      former_state  <= former_state_nx;
      next_state    <= next_state_nx;
      former_done_q <= former_done;
      next_done_q   <= next_done;
      bank_full     <= bank_full_nx;
      if (former_finish) wr_bank <= ~wr_bank;
      if (next_finish) begin
        rd_bank     <= ~rd_bank;
        frames_done <= frames_done + FRAME_ONE;
      end
    end
  end

  // Done is a level; only a rise seen while running ends the frame.
  always_comb begin
    former_state_nx = former_state;
    former_reset    = 1'b0;
    former_enable   = 1'b0;
    former_finish   = 1'b0;
    case (former_state)
      ST_RST: begin
        former_reset    = 1'b1;
        former_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (enable && !bank_full[wr_bank]) former_state_nx = ST_RUN;
      end
      ST_RUN: begin
        former_enable = enable;
        if (former_done && !former_done_q) begin
          former_finish   = 1'b1;
          former_state_nx = ST_RST;
        end
      end
      default: former_state_nx = ST_RST;
    endcase
  end

  always_comb begin
    next_state_nx = next_state;
    next_reset    = 1'b0;
    next_enable   = 1'b0;
    next_finish   = 1'b0;
    case (next_state)
      ST_RST: begin
        next_reset    = 1'b1;
        next_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (enable && bank_full[rd_bank]) next_state_nx = ST_RUN;
      end
      ST_RUN: begin
        next_enable = enable;
        if (next_done && !next_done_q) begin
          next_finish   = 1'b1;
          next_state_nx = ST_RST;
        end
      end
      default: next_state_nx = ST_RST;
    endcase
  end

  // Simultaneous finishes always target different banks, so both bits can update.
  always_comb begin
    bank_full_nx = bank_full;
    if (former_finish) bank_full_nx[wr_bank] = 1'b1;
    if (next_finish)   bank_full_nx[rd_bank] = 1'b0;
  end

  assign former_sel[0] = (former_state == ST_RUN) && !wr_bank;
  assign former_sel[1] = (former_state == ST_RUN) &&  wr_bank;
  assign next_sel[0]   = (next_state == ST_RUN) && !rd_bank && !former_sel[0];
  assign next_sel[1]   = (next_state == ST_RUN) &&  rd_bank && !former_sel[1];

  // The consuming layer never gets a write strobe onto a bank.
  assign bank0_addr_a = former_sel[0] ? former_addr_a : (next_sel[0] ? next_addr_a : '0);
  assign bank0_addr_b = former_sel[0] ? former_addr_b : (next_sel[0] ? next_addr_b : '0);
  assign bank0_rden_a = former_sel[0] ? former_rden_a : (next_sel[0] & next_rden_a);
  assign bank0_rden_b = former_sel[0] ? former_rden_b : (next_sel[0] & next_rden_b);
  assign bank0_wren_a = former_sel[0] & former_wren_a;
  assign bank0_wren_b = former_sel[0] & former_wren_b;

  assign bank1_addr_a = former_sel[1] ? former_addr_a : (next_sel[1] ? next_addr_a : '0);
  assign bank1_addr_b = former_sel[1] ? former_addr_b : (next_sel[1] ? next_addr_b : '0);
  assign bank1_rden_a = former_sel[1] ? former_rden_a : (next_sel[1] & next_rden_a);
  assign bank1_rden_b = former_sel[1] ? former_rden_b : (next_sel[1] & next_rden_b);
  assign bank1_wren_a = former_sel[1] & former_wren_a;
  assign bank1_wren_b = former_sel[1] & former_wren_b;

  assign next_q_a = rd_bank ? bank1_q_a : bank0_q_a;
  assign next_q_b = rd_bank ? bank1_q_b : bank0_q_b;

endmodule

// File: tb/tb_layer_pingpong_scheduler.sv
// Bench for layer_pingpong_scheduler: directed vector table, hand sequences and random traffic.
// A frame-count model of the banks predicts every output each cycle.
module tb_layer_pingpong_scheduler;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_RUN  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          former_done = 1'b0;
  logic          next_done = 1'b0;
  logic [AW-1:0] former_addr_a = '0, former_addr_b = '0;
  logic          former_rden_a = 1'b0, former_rden_b = 1'b0;
  logic          former_wren_a = 1'b0, former_wren_b = 1'b0;
  logic [AW-1:0] next_addr_a = '0, next_addr_b = '0;
  logic          next_rden_a = 1'b0, next_rden_b = 1'b0;
  logic [DW-1:0] bank0_q_a = '0, bank0_q_b = '0, bank1_q_a = '0, bank1_q_b = '0;

  logic          former_enable, former_reset, next_enable, next_reset;
  logic [AW-1:0] bank0_addr_a, bank0_addr_b, bank1_addr_a, bank1_addr_b;
  logic          bank0_rden_a, bank0_rden_b, bank0_wren_a, bank0_wren_b;
  logic          bank1_rden_a, bank1_rden_b, bank1_wren_a, bank1_wren_b;
  logic [DW-1:0] next_q_a, next_q_b;
  logic          wr_bank, rd_bank;
  logic [1:0]    bank_full;
  logic [FW-1:0] frames_done;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  layer_pingpong_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_CNT_WIDTH(FW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .former_enable(former_enable), .former_reset(former_reset), .former_done(former_done),
    .next_enable(next_enable), .next_reset(next_reset), .next_done(next_done),
    .former_addr_a(former_addr_a), .former_addr_b(former_addr_b),
    .former_rden_a(former_rden_a), .former_rden_b(former_rden_b),
    .former_wren_a(former_wren_a), .former_wren_b(former_wren_b),
    .next_addr_a(next_addr_a), .next_addr_b(next_addr_b),
    .next_rden_a(next_rden_a), .next_rden_b(next_rden_b),
    .bank0_addr_a(bank0_addr_a), .bank0_addr_b(bank0_addr_b),
    .bank1_addr_a(bank1_addr_a), .bank1_addr_b(bank1_addr_b),
    .bank0_rden_a(bank0_rden_a), .bank0_rden_b(bank0_rden_b),
    .bank0_wren_a(bank0_wren_a), .bank0_wren_b(bank0_wren_b),
    .bank1_rden_a(bank1_rden_a), .bank1_rden_b(bank1_rden_b),
    .bank1_wren_a(bank1_wren_a), .bank1_wren_b(bank1_wren_b),
    .bank0_q_a(bank0_q_a), .bank0_q_b(bank0_q_b), .bank1_q_a(bank1_q_a), .bank1_q_b(bank1_q_b),
    .next_q_a(next_q_a), .next_q_b(next_q_b),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .bank_full(bank_full), .frames_done(frames_done)
  );

  // Model: banks are tracked only as frames written and frames read since reset.
  int   m_fph = PH_RST, m_nph = PH_RST;
  int   m_wcnt = 0, m_rcnt = 0;
  logic m_fd_prev = 1'b0, m_nd_prev = 1'b0;
  logic m_f_fin, m_n_fin, m_f_go, m_n_go;

  assign m_f_fin = (m_fph == PH_RUN) && former_done && !m_fd_prev;
  assign m_n_fin = (m_nph == PH_RUN) && next_done && !m_nd_prev;
  assign m_f_go  = (m_fph == PH_WAIT) && enable && ((m_wcnt - m_rcnt) < 2);
  assign m_n_go  = (m_nph == PH_WAIT) && enable && ((m_wcnt - m_rcnt) >= 1);

  always @(posedge clock) begin
    if (reset) begin
      m_fph  <= PH_RST;
      m_nph  <= PH_RST;
      m_wcnt <= 0;
      m_rcnt <= 0;
    end else begin
      if (m_fph == PH_RST) m_fph <= PH_WAIT;
      else if (m_f_go) m_fph <= PH_RUN;
      else if (m_f_fin) m_fph <= PH_RST;
      if (m_nph == PH_RST) m_nph <= PH_WAIT;
      else if (m_n_go) m_nph <= PH_RUN;
      else if (m_n_fin) m_nph <= PH_RST;
      if (m_f_fin) m_wcnt <= m_wcnt + 1;
      if (m_n_fin) m_rcnt <= m_rcnt + 1;
    end
    m_fd_prev <= former_done;
    m_nd_prev <= next_done;
  end

  typedef struct packed {
    logic       rst, en, fd, nd;
    logic [3:0] ctrl;
    logic       wr, rd;
    logic [1:0] full;
    logic [7:0] frames;
  } vec_t;

  vec_t tbl [18];

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput();
    int         cnt;
    logic       ew, er;
    logic [1:0] efull;
    logic [2*AW+3:0] eb [2];
    cnt   = m_wcnt - m_rcnt;
    ew    = m_wcnt[0];
    er    = m_rcnt[0];
    efull = 2'b00;
    if (cnt >= 1) efull[er] = 1'b1;
    if (cnt == 2) efull[~er] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (m_fph == PH_RUN && int'(ew) == k)
        eb[k] = {former_addr_a, former_addr_b, former_rden_a, former_rden_b, former_wren_a, former_wren_b};
      else if (m_nph == PH_RUN && int'(er) == k)
        eb[k] = {next_addr_a, next_addr_b, next_rden_a, next_rden_b, 2'b00};
      else
        eb[k] = '0;
    end
    compare("ctrl", 64'({former_reset, former_enable, next_reset, next_enable}),
            64'({m_fph == PH_RST, m_fph == PH_RUN && enable, m_nph == PH_RST, m_nph == PH_RUN && enable}));
    compare("ptrs", 64'({wr_bank, rd_bank, bank_full, frames_done}), 64'({ew, er, efull, m_rcnt[FW-1:0]}));
    compare("bank0", 64'({bank0_addr_a, bank0_addr_b, bank0_rden_a, bank0_rden_b, bank0_wren_a, bank0_wren_b}), 64'(eb[0]));
    compare("bank1", 64'({bank1_addr_a, bank1_addr_b, bank1_rden_a, bank1_rden_b, bank1_wren_a, bank1_wren_b}), 64'(eb[1]));
    compare("next_q", 64'({next_q_a, next_q_b}), 64'(er ? {bank1_q_a, bank1_q_b} : {bank0_q_a, bank0_q_b}));
    if (former_enable && next_enable)
      compare("wr_ne_rd", 64'(wr_bank ^ rd_bank), 64'd1);
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic fd, input logic nd);
    @(posedge clock);
    #1;
    reset       = rst;
    enable      = en;
    former_done = fd;
    next_done   = nd;
    @(negedge clock);
    checkOutput();
  endtask

  task automatic randomBus();
    former_addr_a = AW'($urandom);
    former_addr_b = AW'($urandom);
    former_rden_a = 1'($urandom);
    former_rden_b = 1'($urandom);
    former_wren_a = 1'($urandom);
    former_wren_b = 1'($urandom);
    next_addr_a   = AW'($urandom);
    next_addr_b   = AW'($urandom);
    next_rden_a   = 1'($urandom);
    next_rden_b   = 1'($urandom);
    bank0_q_a     = DW'($urandom);
    bank0_q_b     = DW'($urandom);
    bank1_q_a     = DW'($urandom);
    bank1_q_b     = DW'($urandom);
  endtask

  initial begin
    logic ok;
    logic fd_t, nd_t;
    // ctrl = {former_reset, former_enable, next_reset, next_enable}
    tbl[0]  = {1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 2'b00, 8'd0};
    tbl[1]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 2'b00, 8'd0};
    tbl[2]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 8'd0};
    tbl[3]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 2'b00, 8'd0};
    tbl[4]  = {1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 8'd0};
    tbl[5]  = {1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 2'b00, 8'd0};
    tbl[6]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 2'b01, 8'd0};
    tbl[7]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 2'b01, 8'd0};
    tbl[8]  = {1'b0, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 2'b01, 8'd0};
    tbl[9]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 2'b11, 8'd0};
    tbl[10] = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b11, 8'd0};
    tbl[11] = {1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 2'b11, 8'd0};
    tbl[12] = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 2'b10, 8'd1};
    tbl[13] = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 2'b10, 8'd1};
    tbl[14] = {1'b0, 1'b1, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b1, 2'b10, 8'd1};
    tbl[15] = {1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 2'b01, 8'd2};
    tbl[16] = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b01, 8'd2};
    tbl[17] = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 2'b01, 8'd2};

    for (int i = 0; i < 18; i++) begin
      randomBus();
      applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].fd, tbl[i].nd);
      compare("tbl_ctrl", 64'({former_reset, former_enable, next_reset, next_enable}), 64'(tbl[i].ctrl));
      compare("tbl_ptrs", 64'({wr_bank, rd_bank, bank_full, frames_done}),
              64'({tbl[i].wr, tbl[i].rd, tbl[i].full, tbl[i].frames}));
    end

    // Former on bank1, next on bank0: buses must be steered apart.
    former_addr_a = 9'd5;  former_wren_a = 1'b1; former_rden_a = 1'b0;
    next_addr_a   = 9'd7;  next_rden_a   = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    compare("steer_b1_addr", 64'(bank1_addr_a), 64'd5);
    compare("steer_b1_wren", 64'(bank1_wren_a), 64'd1);
    compare("steer_b0_addr", 64'(bank0_addr_a), 64'd7);
    compare("steer_b0_wren", 64'({bank0_wren_a, bank0_wren_b}), 64'd0);

    // Fill bank1, drain bank0, then let next read bank1.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      ok = next_enable && rd_bank;
    end
    compare("wait_next_bank1", 64'(ok), 64'd1);
    next_rden_a = 1'b1; former_wren_a = 1'b1; former_wren_b = 1'b1;
    bank1_q_a = 16'hBEEF; bank0_q_a = 16'h1234;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    compare("rd1_rden", 64'(bank1_rden_a), 64'd1);
    compare("rd1_wren", 64'({bank1_wren_a, bank1_wren_b}), 64'd0);
    compare("rd1_q", 64'(next_q_a), 64'hBEEF);

    // Reset while running returns everything to reset values on the next edge.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    compare("rst_ctrl", 64'({former_reset, former_enable, next_reset, next_enable}), 64'b1010);
    compare("rst_ptrs", 64'({wr_bank, rd_bank, bank_full, frames_done}), 64'd0);
    compare("rst_strobes", 64'({bank0_rden_a, bank0_rden_b, bank0_wren_a, bank0_wren_b,
                                bank1_rden_a, bank1_rden_b, bank1_wren_a, bank1_wren_b}), 64'd0);

    // Toggling done levels give a rise every other cycle; run until 256 frames consumed.
    ok = 1'b0; fd_t = 1'b0; nd_t = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      randomBus();
      fd_t = ~fd_t; nd_t = ~nd_t;
      applyStimulus(1'b0, 1'b1, fd_t, nd_t);
      if (m_rcnt == 256) begin
        ok = 1'b1;
        compare("frames_wrap", 64'(frames_done), 64'd0);
      end
    end
    compare("wrap_reached", 64'(ok), 64'd1);

    for (int i = 0; i < 1500; i++) begin
      randomBus();
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/layer_pingpong_scheduler.md
# layer_pingpong_scheduler

Double-buffer (ping-pong) scheduler between two adjacent CNN layers, such as conv→conv or conv→fc. It owns two identical dual-port feature RAM banks. The producing ("former") layer fills one bank while the consuming ("next") layer reads the other. The scheduler sequences each layer's enable/reset, steers both layers' port-A/B address and strobe buses onto the correct bank, and muxes bank read data back to the next layer. The block sits between a `layer_N` instance and a `layer_N+1` instance, and replaces hard-wired single-buffer handoff with overlapped execution.

## Interface
- `ADDR_WIDTH`, 9: bank address width.
- `DATA_WIDTH`, 16: bank data word width.
- `FRAME_CNT_WIDTH`, 8: width of completed-frame counter.

Ports:
- `clock`, in, 1: single clock. Every flop samples on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: global run permission.
- `former_enable` / `former_reset`, out, 1 each: former-layer control.
- `former_done`, in, 1: former layer finished a frame. Level signal, cleared by `former_reset`.
- `next_enable` / `next_reset`, out, 1 each: next-layer control.
- `next_done`, in, 1: next layer finished consuming a frame. Level signal.
- `former_addr_a` / `former_addr_b`, in, ADDR_WIDTH: former-layer write-side addresses.
- `former_rden_a`, `former_rden_b`, `former_wren_a`, `former_wren_b`, in, 1 each: former-layer strobes.
- `next_addr_a` / `next_addr_b`, in, ADDR_WIDTH: next-layer read-side addresses.
- `next_rden_a` / `next_rden_b`, in, 1 each: next-layer read strobes.
- `bank0_addr_a`, `bank0_addr_b`, `bank1_addr_a`, `bank1_addr_b`, out, ADDR_WIDTH: bank addresses.
- `bankK_rden_a`, `bankK_rden_b`, `bankK_wren_a`, `bankK_wren_b` (K=0,1), out, 1 each: bank strobes.
- `bank0_q_a`, `bank0_q_b`, `bank1_q_a`, `bank1_q_b`, in, DATA_WIDTH: bank read data.
- `next_q_a` / `next_q_b`, out, DATA_WIDTH: read data returned to the next layer.
- `wr_bank` / `rd_bank`, out, 1 each: current bank pointers.
- `bank_full`, out, 2: per-bank full flags.
- `frames_done`, out, FRAME_CNT_WIDTH: count of frames consumed.

## Operation
- The former side and the next side each run an independent 3-state FSM: RST → WAIT → RUN → RST.
- RST state:
  - drives `*_reset`=1 and `*_enable`=0;
  - always moves to WAIT after one cycle.
- WAIT state:
  - drives reset=0 and enable=0;
  - former side moves to RUN when `enable` && !`bank_full[wr_bank]`;
  - next side moves to RUN when `enable` && `bank_full[rd_bank]`.
- RUN state:
  - drives enable=`enable` and reset=0;
  - a low `enable` only freezes the layer; the FSM stays in RUN;
  - on a rising edge of `*_done` (current done high, registered done low), the FSM moves to RST.
- Former RUN→RST: set `bank_full[wr_bank]` and toggle `wr_bank`.
- Next RUN→RST: clear `bank_full[rd_bank]`, toggle `rd_bank`, and increment `frames_done` (it wraps at 2^FRAME_CNT_WIDTH−1 → 0).
- Both sides may finish in the same cycle. Both updates apply; they always target different banks.
- Invariant: `wr_bank`≠`rd_bank` whenever both FSMs are in RUN. The bench asserts this.
- Bank steering is combinational from the registered state:
  - bank k follows the former buses when former is in RUN and `wr_bank`==k;
  - otherwise bank k follows the next buses when next is in RUN and `rd_bank`==k. In that case wren is forced to 0, so the next layer can never write;
  - otherwise bank k gets address 0 and all strobes 0.
- Read data mux: `next_q_a/b` = `rd_bank` ? `bank1_q_a/b` : `bank0_q_a/b`.
- A `done` level that is already high on entry to RUN is ignored until it goes low and rises again.

## Timing
- Reset values:
  - both FSMs in RST, so `former_reset`=`next_reset`=1 and both enables are 0;
  - `wr_bank`=`rd_bank`=0, `bank_full`=2'b00, `frames_done`=0;
  - all bank strobes 0.
- Reset asserted mid-operation: on the next edge the block returns to the reset values. Bank contents are not invalidated; they are simply treated as empty.
- First cycle after reset deasserts: RST, resets still 1. Second cycle: WAIT. Third cycle: former enters RUN if `enable`=1.
- `former_done` rising at edge t:
  - t+1: former in RST, `bank_full[old wr_bank]`=1, `wr_bank` toggled;
  - t+2: former in WAIT, and next enters RUN if it was waiting on that bank;
  - t+3: former enters RUN if the new bank is empty.
- `next_done` rising at edge t:
  - t+1: bank cleared, `rd_bank` toggled, `frames_done` incremented;
  - t+2: a waiting former on that bank may enter RUN.
- Both banks full: the former side stalls in WAIT until a `next_done` frees a bank.

## Test plan
- Reset, then `enable`=1 with no done pulses → resets high for 2 cycles, `former_enable`=1 from cycle 3, `next_enable` stays 0, `bank_full`=00.
- `former_done` rise → `bank_full`=01 and `wr_bank`=1 at t+1; `next_enable`=1 at t+2; former runs on bank1 at t+3. Former wren on `former_addr_a`=5 appears on `bank1_addr_a`=5 while bank0 gets the next-side address.
- The next layer is slow and the former finishes bank1 → `bank_full`=11; former held in WAIT until `next_done`; `frames_done`=1 afterwards.
- `former_done` and `next_done` rise in the same cycle → both pointers toggle, `bank_full` updates on both bits, and `wr_bank`≠`rd_bank` holds throughout.
- Next asserts `next_wren`-equivalent strobes / `next_rden_a`=1 with `rd_bank`=1 → `bank1_rden_a`=1, `bank1_wren_*`=0, and `next_q_a` equals `bank1_q_a`.
- 256 full frames → `frames_done` wraps to 0. Reset asserted mid-RUN → all outputs return to reset values the next cycle.
